fetch_pc_ras: RTL and testbench
===============================

# fetch_pc_ras

Parametrised program-counter unit for the F stage. Holds the fetch PC with a configurable reset vector, legal address window and exception vector. Applies redirects in a fixed priority: exception entry, `eret` return, D-stage branch/jump redirect, then sequential +4. Adds a circular return-address stack (RAS) so D-stage `jr $ra` can predict its target before the register value is forwarded.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, PC value after reset
- `ADDR_LO`, 32'h0000_3000, lowest legal fetch address
- `ADDR_HI`, 32'h0000_6FFC, highest legal fetch address (inclusive)
- `EXC_PC`, 32'h0000_4180, exception/interrupt handler entry
- `RAS_DEPTH`, 4, RAS entries; power of two, ≥ 2

Ports:
- `clk`, in, 1, clock
- `rst`, in, 1, synchronous reset, active-high
- `stall`, in, 1, hold PC (hazard stall)
- `req`, in, 1, exception/interrupt taken; load `EXC_PC`
- `eret`, in, 1, D-stage `eret`; load `epc`
- `epc`, in, 32, return address from CP0
- `redirect`, in, 1, D-stage branch/jump taken
- `redirect_pc`, in, 32, target for `redirect`
- `ras_push`, in, 1, D-stage call (`jal`/`jalr`)
- `ras_push_addr`, in, 32, return address to push (call PC + 8)
- `ras_pop`, in, 1, D-stage `jr $31`
- `pc`, out, 32, current fetch address (registered)
- `pc_plus4`, out, 32, `pc + 4`, modulo 2^32
- `f_exc_adel`, out, 1, fetch address error
- `ras_top`, out, 32, current top-of-stack entry
- `ras_valid`, out, 1, RAS non-empty

## Operation
- Next-PC priority, evaluated at each posedge:
  - `rst` → `RESET_PC`
  - `req` → `EXC_PC`
  - `eret` → `epc`
  - `redirect` → `redirect_pc`
  - `stall` → hold
  - otherwise → `pc + 4`
- `req`, `eret` and `redirect` override `stall`. `pc` is never combinationally muxed; it changes only at a clock edge.
- `f_exc_adel` = `pc[1:0] != 0` OR `pc < ADDR_LO` OR `pc > ADDR_HI`. Comparisons are unsigned 32-bit. The output is purely combinational from `pc` and stays asserted while an illegal `pc` is held under stall.
- RAS state: `RAS_DEPTH` × 32 entry array, top pointer `tp` (log2(`RAS_DEPTH`) bits, wraps), and `cnt` (0..`RAS_DEPTH`).
  - `ras_top` = `entry[tp]`; `ras_valid` = (`cnt != 0`).
  - Push only: `tp` ← `tp + 1`, write the entry, `cnt` ← min(`cnt + 1`, `RAS_DEPTH`). A push when full overwrites the oldest entry through wrap; `cnt` stays at `RAS_DEPTH`.
  - Pop only, `cnt > 0`: `tp` ← `tp − 1`, `cnt` ← `cnt − 1`. Pop when empty has no effect.
  - Push and pop together: overwrite `entry[tp]` with `ras_push_addr`. `tp` is unchanged. `cnt` ← max(`cnt`, 1).
  - `req` clears `cnt` to 0 and sets `tp` to 0, same cycle as the PC load. It takes precedence over push/pop.
  - `stall` does not gate push/pop. Upstream asserts them for exactly one cycle per D-stage instruction.
- The RAS is a hint only. This block never uses `ras_top` to steer `pc`; D stage selects it and sends it through `redirect`.

## Timing
- Reset values: `pc` = `RESET_PC`, `pc_plus4` = `RESET_PC + 4`, `f_exc_adel` from `RESET_PC` (0 with defaults), `cnt` = 0, `tp` = 0, `ras_valid` = 0. Entry contents are don't-care; `ras_top` is undefined while `ras_valid` = 0.
- Every load has 1-cycle latency: inputs sampled at edge N appear on `pc` after edge N.
- A push at edge N makes `ras_top` = `ras_push_addr` and `ras_valid` = 1 after edge N.
- Reset mid-operation discards any pending redirect, push or pop in that cycle.
- Sequential `pc + 4` from 32'hFFFF_FFFC wraps to 0 without error. AdEL then flags it.

## Test plan
- Reset, then 3 free-running cycles → `pc` = 3000, 3004, 3008, 300C. `f_exc_adel` = 0 throughout.
- `stall` = 1 at `pc` = 3008 while `redirect` = 1, `redirect_pc` = 3100 → next `pc` = 3100. Then `stall` alone for 2 cycles → `pc` holds 3100.
- `redirect_pc` = 7000, then `redirect_pc` = 3002 → `f_exc_adel` = 1 for each. Then `req` = 1 together with `eret` = 1 → `pc` = 4180, `f_exc_adel` = 0.
- `eret` with `epc` = 3040 → `pc` = 3040 the next cycle. Repeat with `stall` = 1 → same result.
- Push 3008, 3010, 3018, 3020, 3028 with `RAS_DEPTH` = 4, then pop 5 times. Required `ras_top` before each pop: 3028, 3020, 3018, 3010. After the fourth pop `ras_valid` = 0. The fifth pop has no effect.
- On an empty RAS, push + pop with addr 3050 → `ras_valid` = 1, `ras_top` = 3050. Then `req` → `ras_valid` = 0, `pc` = 4180.

Source files
------------

// File: rtl/fetch_pc_ras.sv
// rtl/fetch_pc_ras.sv - F-stage fetch PC with redirect priority and circular return-address stack
module fetch_pc_ras #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] ADDR_LO   = 32'h0000_3000,
    parameter logic [31:0] ADDR_HI   = 32'h0000_6FFC,
    parameter logic [31:0] EXC_PC    = 32'h0000_4180,
    parameter int          RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        ras_push,
    input  logic [31:0] ras_push_addr,
    input  logic        ras_pop,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        f_exc_adel,
    output logic [31:0] ras_top,
    output logic        ras_valid
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] tp_q, tp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   entry_q [RAS_DEPTH];
    logic [31:0]   entry_d [RAS_DEPTH];

    assign pc        = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign ras_top   = entry_q[tp_q];
    assign ras_valid = (cnt_q != '0);

    // Fetch address error: misaligned or outside the legal window, straight off the registered PC
    always_comb begin
        f_exc_adel = (pc_q[1:0] != 2'b00) || (pc_q < ADDR_LO) || (pc_q > ADDR_HI);
    end

    // Next-PC selection: exception, eret, redirect all beat stall; otherwise sequential
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (req) begin
            pc_d = EXC_PC;
        end else if (eret) begin
            pc_d = epc;
        end else if (redirect) begin
            pc_d = redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    // RAS update: push+pop replaces the top in place; exception entry empties the stack
    always_comb begin
        tp_d    = tp_q;
        cnt_d   = cnt_q;
        entry_d = entry_q;
        if (req) begin
            tp_d  = '0;
            cnt_d = '0;
        end else if (ras_push && ras_pop) begin
            entry_d[tp_q] = ras_push_addr;
            if (cnt_q == '0) begin
                cnt_d = CW'(1);
            end
        end else if (ras_push) begin
            tp_d          = tp_q + PW'(1);
            entry_d[tp_d] = ras_push_addr;
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (ras_pop && (cnt_q != '0)) begin
            tp_d  = tp_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    // PC and stack pointers reset; entry contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            tp_q  <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            tp_q  <= tp_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage only changes on a non-reset cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            entry_q <= entry_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_ras.sv
// tb/tb_fetch_pc_ras.sv - directed scoreboard bench for fetch_pc_ras
module tb_fetch_pc_ras;

    logic        clk = 1'b0;
    logic        rst, stall, req, eret, redirect, ras_push, ras_pop;
    logic [31:0] epc, redirect_pc, ras_push_addr;
    logic [31:0] pc, pc_plus4, ras_top;
    logic        f_exc_adel, ras_valid;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        adel;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mpc;

    fetch_pc_ras dut (
        .clk(clk), .rst(rst), .stall(stall), .req(req), .eret(eret), .epc(epc),
        .redirect(redirect), .redirect_pc(redirect_pc), .ras_push(ras_push),
        .ras_push_addr(ras_push_addr), .ras_pop(ras_pop), .pc(pc), .pc_plus4(pc_plus4),
        .f_exc_adel(f_exc_adel), .ras_top(ras_top), .ras_valid(ras_valid)
    );

    always #5 clk = ~clk;

    function automatic logic adel_of(input logic [31:0] p);
        return (p[1:0] != 2'b00) || (p < 32'h0000_3000) || (p > 32'h0000_6FFC);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        rst = 0; stall = 0; req = 0; eret = 0; redirect = 0; ras_push = 0; ras_pop = 0;
        epc = '0; redirect_pc = '0; ras_push_addr = '0;
    endtask

    // Inputs are set at a negedge; queue the expected PC, clock once, compare, return at next negedge
    task automatic tick(input string tag);
        exp_t e;
        if (rst)           mpc = 32'h0000_3000;
        else if (req)      mpc = 32'h0000_4180;
        else if (eret)     mpc = epc;
        else if (redirect) mpc = redirect_pc;
        else if (!stall)   mpc = mpc + 32'd4;
        sb.push_back('{tag, mpc, adel_of(mpc)});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".pc"}, pc, e.pc);
        chk({e.tag, ".pc_plus4"}, pc_plus4, e.pc + 32'd4);
        chk({e.tag, ".adel"}, {31'd0, f_exc_adel}, {31'd0, e.adel});
        @(negedge clk);
        clear_in();
    endtask

    task automatic push(input logic [31:0] a);
        ras_push = 1; ras_push_addr = a; tick("push");
    endtask

    task automatic pop();
        ras_pop = 1; tick("pop");
    endtask

    initial begin
        clear_in();
        mpc = '0;
        @(negedge clk);
        rst = 1; tick("reset");
        chk("reset.ras_valid", {31'd0, ras_valid}, 32'd0);

        tick("seq1"); tick("seq2"); tick("seq3");

        redirect = 1; redirect_pc = 32'h3008; tick("redir3008");
        stall = 1; redirect = 1; redirect_pc = 32'h3100; tick("stall_redir");
        stall = 1; tick("stall1");
        stall = 1; tick("stall2");

        redirect = 1; redirect_pc = 32'h7000; tick("redir_hi");
        redirect = 1; redirect_pc = 32'h3002; tick("redir_misal");
        stall = 1; tick("stall_misal");
        req = 1; eret = 1; epc = 32'h3040; tick("req_eret");

        eret = 1; epc = 32'h3040; tick("eret");
        tick("seq_after_eret");
        eret = 1; epc = 32'h3040; stall = 1; tick("eret_stall");

        push(32'h3008); push(32'h3010); push(32'h3018); push(32'h3020); push(32'h3028);
        chk("ras.full_valid", {31'd0, ras_valid}, 32'd1);
        chk("ras.top0", ras_top, 32'h3028); pop();
        chk("ras.top1", ras_top, 32'h3020); pop();
        chk("ras.top2", ras_top, 32'h3018); pop();
        chk("ras.top3", ras_top, 32'h3010); pop();
        chk("ras.empty_valid", {31'd0, ras_valid}, 32'd0);
        pop();
        chk("ras.pop_empty_valid", {31'd0, ras_valid}, 32'd0);
        push(32'h3080);
        chk("ras.repush_top", ras_top, 32'h3080);
        chk("ras.repush_valid", {31'd0, ras_valid}, 32'd1);
        pop();
        chk("ras.repop_valid", {31'd0, ras_valid}, 32'd0);

        ras_push = 1; ras_pop = 1; ras_push_addr = 32'h3050; tick("pushpop");
        chk("ras.pushpop_valid", {31'd0, ras_valid}, 32'd1);
        chk("ras.pushpop_top", ras_top, 32'h3050);
        req = 1; tick("req_clear");
        chk("ras.req_valid", {31'd0, ras_valid}, 32'd0);

        req = 1; ras_push = 1; ras_push_addr = 32'h3300; tick("req_push");
        chk("ras.req_push_valid", {31'd0, ras_valid}, 32'd0);

        redirect = 1; redirect_pc = 32'hFFFF_FFFC; tick("redir_top");
        tick("wrap");

        push(32'h3400);
        rst = 1; redirect = 1; redirect_pc = 32'h3500; ras_push = 1; ras_push_addr = 32'h3600; tick("rst_mid");
        chk("rst_mid.ras_valid", {31'd0, ras_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
